// File: rtl/dispatch_queue.sv
// In-order dispatch queue between decode and the functional-unit reservation
// stations. Packets are buffered in a small flop FIFO and the head entry is
// offered to exactly one FU channel (BR > MEM > ALU priority). A stalled head
// blocks all younger entries, so dispatch stays in strict program order.

package dispatch_queue_pkg;

  // Decoded instruction as handed over by decode.
  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic        fu_br;
    logic        fu_mem;
    logic        fu_alu;
  } decode_data;

  // Routing class of the head entry.
  typedef enum logic [1:0] {
    FU_NONE = 2'd0,
    FU_ALU  = 2'd1,
    FU_MEM  = 2'd2,
    FU_BR   = 2'd3
  } fu_class_e;

endpackage

module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   valid_in,
  output logic                   ready_in,
  input  decode_data             data_in,
  output decode_data             data_out,
  output logic                   alu_valid,
  input  logic                   alu_ready,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic                   br_valid,
  input  logic                   br_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  decode_data       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  decode_data head;
  fu_class_e  head_cls;
  logic       not_empty;
  logic       offer;
  logic       sel_ready;
  logic       enq;
  logic       deq;
  logic       stall_evt;

  assign not_empty = (count != '0);
  assign head      = mem[rd_ptr];

  // No full-bypass: a full queue refuses input even if the head leaves this cycle.
  assign ready_in  = (count < FULL_CNT) && !flush;
  assign enq       = valid_in && ready_in;

  // Classify the head entry; BR wins over MEM, MEM over ALU.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    head_cls = FU_NONE;
    if (head.fu_br)       head_cls = FU_BR;
    else if (head.fu_mem) head_cls = FU_MEM;
    else if (head.fu_alu) head_cls = FU_ALU;
  end

  // Drive the per-channel offers and the shared head data.
  always_comb begin
    offer     = not_empty && !flush && (head_cls != FU_NONE);
    alu_valid = offer && (head_cls == FU_ALU);
    mem_valid = offer && (head_cls == FU_MEM);
    br_valid  = offer && (head_cls == FU_BR);
    data_out  = not_empty ? head : '0;
  end

  // Pick the ready of the channel the head is routed to; other readies are ignored.
  always_comb begin
    sel_ready = 1'b0;
    unique case (head_cls)
      FU_ALU:  sel_ready = alu_ready;
      FU_MEM:  sel_ready = mem_ready;
      FU_BR:   sel_ready = br_ready;
      default: sel_ready = 1'b0;
    endcase
  end

  // A NONE-class head is dropped on the next edge without ever being offered.
  assign deq       = not_empty && !flush && ((head_cls == FU_NONE) || sel_ready);
  assign stall_evt = offer && !sel_ready;

  // Pointer and occupancy update; flush overrides any enqueue/dequeue.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({enq, deq})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage written at the tail on each accepted packet.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count gates every read, so stale entries are never visible.
    if (enq) mem[wr_ptr] <= data_in;
  end

  // Saturating count of cycles the head was offered but refused; flush leaves it alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (stall_evt && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue. A queue-based reference model tracks the
// expected contents and stall count; a compare process checks all outputs
// every falling edge, and the stimulus adds hand-computed literal checks.

module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush;
  logic             valid_in;
  logic             ready_in;
  decode_data       data_in;
  decode_data       data_out;
  logic             alu_valid, alu_ready;
  logic             mem_valid, mem_ready;
  logic             br_valid, br_ready;
  logic [2:0]       count;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dispatch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .data_out  (data_out),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .br_valid  (br_valid),
    .br_ready  (br_ready),
    .count     (count),
    .stall_cnt (stall_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic decode_data pkt(input logic [31:0] pc, input logic br, input logic mm,
                                     input logic alu);
    decode_data d;
    d.pc     = pc;
    d.opcode = pc[8:2] ^ 7'h33;
    d.fu_br  = br;
    d.fu_mem = mm;
    d.fu_alu = alu;
    return d;
  endfunction

  // ---------------- reference model ----------------
  decode_data  q[$];
  int unsigned m_stall = 0;

  function automatic fu_class_e cls_of(input decode_data d);
    if (d.fu_br)  return FU_BR;
    if (d.fu_mem) return FU_MEM;
    if (d.fu_alu) return FU_ALU;
    return FU_NONE;
  endfunction

  function automatic logic ready_for(input fu_class_e c);
    case (c)
      FU_ALU:  return alu_ready;
      FU_MEM:  return mem_ready;
      FU_BR:   return br_ready;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void model_step();
    logic do_deq;
    logic do_enq;
    fu_class_e c;
    if (!reset_n) begin
      q.delete();
      m_stall = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      do_deq = 1'b0;
      do_enq = valid_in && (q.size() < DEPTH);
      if (q.size() > 0) begin
        c = cls_of(q[0]);
        if (c == FU_NONE)      do_deq = 1'b1;
        else if (ready_for(c)) do_deq = 1'b1;
        else if (m_stall < (2 ** CNT_W) - 1) m_stall = m_stall + 1;
      end
      if (do_deq) void'(q.pop_front());
      if (do_enq) q.push_back(data_in);
    end
  endfunction

  always @(posedge clk or negedge reset_n) model_step();

  // Compare every DUT output against the model once per cycle.
  always @(negedge clk) begin
    fu_class_e  c;
    logic       offered;
    decode_data exp_data;
    c        = (q.size() > 0) ? cls_of(q[0]) : FU_NONE;
    offered  = (q.size() > 0) && !flush && (c != FU_NONE);
    exp_data = (q.size() > 0) ? q[0] : '0;
    check("cyc_ready_in",  64'(ready_in),  64'((q.size() < DEPTH) && !flush));
    check("cyc_count",     64'(count),     64'(q.size()));
    check("cyc_alu_valid", 64'(alu_valid), 64'(offered && c == FU_ALU));
    check("cyc_mem_valid", 64'(mem_valid), 64'(offered && c == FU_MEM));
    check("cyc_br_valid",  64'(br_valid),  64'(offered && c == FU_BR));
    check("cyc_data_out",  64'(data_out),  64'(exp_data));
    check("cyc_stall_cnt", 64'(stall_cnt), 64'(m_stall));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; valid_in = 1'b0; data_in = '0;
    alu_ready = 1'b0; mem_ready = 1'b0; br_ready = 1'b0;

    // 1: reset release, idle
    repeat (2) tick();
    reset_n = 1'b1;
    tick(); settle();
    check("t1_ready_in", 64'(ready_in), 64'd1);
    check("t1_count", 64'(count), 64'd0);
    check("t1_valids", 64'({alu_valid, mem_valid, br_valid}), 64'd0);
    check("t1_data_out", 64'(data_out), 64'd0);

    // 2: ALU, MEM, BR(+alu bit) dispatched on consecutive cycles
    alu_ready = 1'b1; mem_ready = 1'b1; br_ready = 1'b1;
    valid_in = 1'b1; data_in = pkt(32'h100, 1'b0, 1'b0, 1'b1);
    tick(); data_in = pkt(32'h104, 1'b0, 1'b1, 1'b0); settle();
    check("t2_alu_valid", 64'(alu_valid), 64'd1);
    check("t2_alu_pc", 64'(data_out.pc), 64'h100);
    tick(); data_in = pkt(32'h108, 1'b1, 1'b0, 1'b1); settle();
    check("t2_mem_valid", 64'(mem_valid), 64'd1);
    check("t2_mem_pc", 64'(data_out.pc), 64'h104);
    tick(); valid_in = 1'b0; settle();
    check("t2_br_valid", 64'(br_valid), 64'd1);
    check("t2_br_not_alu", 64'(alu_valid), 64'd0);
    check("t2_br_pc", 64'(data_out.pc), 64'h108);
    tick(); settle();
    check("t2_empty", 64'(count), 64'd0);

    // 3: fill with stalled MEM head, then drain
    mem_ready = 1'b0; valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = pkt(32'h200 + 32'(4 * i), 1'b0, 1'b1, 1'b0);
      tick();
    end
    data_in = pkt(32'h2f0, 1'b0, 1'b0, 1'b1);
    settle();
    check("t3_full_count", 64'(count), 64'd4);
    check("t3_full_ready", 64'(ready_in), 64'd0);
    check("t3_mem_valid", 64'(mem_valid), 64'd1);
    check("t3_stall3", 64'(stall_cnt), 64'd3);
    repeat (2) tick();
    settle();
    check("t3_pc_stable", 64'(data_out.pc), 64'h200);
    check("t3_stall5", 64'(stall_cnt), 64'd5);
    mem_ready = 1'b1; settle();
    check("t3_no_bypass", 64'(ready_in), 64'd0);
    tick(); valid_in = 1'b0; settle();
    check("t3_drain1", 64'(count), 64'd3);
    check("t3_drain_pc", 64'(data_out.pc), 64'h204);
    repeat (3) tick();
    settle();
    check("t3_drained", 64'(count), 64'd0);

    // 4: stalled MEM head blocks a ready ALU behind it
    mem_ready = 1'b0; alu_ready = 1'b1; br_ready = 1'b1;
    valid_in = 1'b1; data_in = pkt(32'h300, 1'b0, 1'b1, 1'b0);
    tick(); data_in = pkt(32'h304, 1'b0, 1'b0, 1'b1);
    tick(); data_in = pkt(32'h308, 1'b0, 1'b0, 1'b1); settle();
    check("t4_alu_blocked", 64'(alu_valid), 64'd0);
    check("t4_mem_head", 64'(mem_valid), 64'd1);
    check("t4_stall6", 64'(stall_cnt), 64'd6);
    tick();

    // 5: flush with count=3 and valid_in=1
    flush = 1'b1; data_in = pkt(32'h30c, 1'b0, 1'b0, 1'b1); settle();
    check("t5_count3", 64'(count), 64'd3);
    check("t5_ready_flush", 64'(ready_in), 64'd0);
    check("t5_valids_flush", 64'({alu_valid, mem_valid, br_valid}), 64'd0);
    check("t5_stall7", 64'(stall_cnt), 64'd7);
    tick(); flush = 1'b0; valid_in = 1'b0; settle();
    check("t5_flushed", 64'(count), 64'd0);
    check("t5_stall_kept", 64'(stall_cnt), 64'd7);

    // 6: NONE entry between two ALU ops is dropped; then async reset mid-stream
    mem_ready = 1'b1;
    valid_in = 1'b1; data_in = pkt(32'h400, 1'b0, 1'b0, 1'b1);
    tick(); data_in = pkt(32'h404, 1'b0, 1'b0, 1'b0); settle();
    check("t6_alu0_pc", 64'(data_out.pc), 64'h400);
    tick(); data_in = pkt(32'h408, 1'b0, 1'b0, 1'b1); settle();
    check("t6_none_hidden", 64'({alu_valid, mem_valid, br_valid}), 64'd0);
    check("t6_none_count", 64'(count), 64'd1);
    tick(); alu_ready = 1'b0; data_in = pkt(32'h500, 1'b0, 1'b0, 1'b1); settle();
    check("t6_alu1_valid", 64'(alu_valid), 64'd1);
    check("t6_alu1_pc", 64'(data_out.pc), 64'h408);
    tick(); valid_in = 1'b0; settle();
    check("t6_pre_reset_count", 64'(count), 64'd2);
    check("t6_stall8", 64'(stall_cnt), 64'd8);
    #1 reset_n = 1'b0;
    #1;
    check("t6_rst_count", 64'(count), 64'd0);
    check("t6_rst_valid", 64'(alu_valid), 64'd0);
    check("t6_rst_data", 64'(data_out), 64'd0);
    check("t6_rst_ready", 64'(ready_in), 64'd1);
    check("t6_rst_stall", 64'(stall_cnt), 64'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick(); settle();
    check("t6_post_count", 64'(count), 64'd0);
    check("t6_post_valids", 64'({alu_valid, mem_valid, br_valid}), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
